dmem_stream_reader: RTL and testbench
=====================================

// Module: dmem_stream_reader
// PURPOSE
//   Sequential read engine that sits directly downstream of the data-memory image ROM.
//   Walks a block of ROM words (base address, word count) by driving the ROM address.
//   Captures each combinational read word into an output register.
//   Presents the words as a valid/ready stream to the pipeline's consumer
//   (image-processing stage / memory-writeback path).
//   Handles range checking, back-pressure, last-word tagging and a completion pulse.
// PARAMETERS
//   DATA_W   32    ROM word width and out_data width
//   DEPTH    8100  number of ROM words; legal word addresses are 0..DEPTH-1
//   CNT_W    14    width of count and of the internal remaining-word counter
// PORTS
//   clk        in   1       system clock, all state updates on rising edge
//   reset      in   1       synchronous, active-high reset
//   start      in   1       request a transfer; sampled only in IDLE
//   base_addr  in   32      first ROM word address of the transfer
//   count      in   CNT_W   number of words to stream; 0 is legal
//   busy       out  1       high in any state other than IDLE
//   done       out  1       one-cycle pulse: transfer finished (or count==0)
//   err        out  1       one-cycle pulse: range error, transfer rejected
//   rom_addr   out  32      word address to ROM; 0 when not in RUN
//   rom_rd     in   DATA_W  combinational ROM read data for rom_addr
//   out_data   out  DATA_W  streamed word, held stable while out_valid && !out_ready
//   out_valid  out  1       out_data holds an unconsumed word
//   out_ready  in   1       consumer accepts; transfer when out_valid && out_ready
//   out_last   out  1       qualifies out_data as final word of the transfer
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; ptr and remaining cleared.
//     Reset wins over every other input at any cycle, including mid-transfer;
//     any in-flight word is discarded.
//   FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE: on start, base_addr and count are latched.
//     count==0 -> DONE, no data.
//     base_addr+count > DEPTH (33-bit compare, no wrap) -> err pulse next cycle; stay IDLE.
//     Otherwise -> RUN with ptr=base_addr and remaining=count.
//   RUN: rom_addr=ptr. Load condition load = !out_valid || out_ready.
//     On load: out_data<=rom_rd; out_valid<=1; out_last<=(remaining==1);
//     ptr++; remaining--.
//     Loading the word with remaining==1 -> DRAIN.
//   Throughput: 1 word/cycle while out_ready stays high.
//   Latency: start sampled at edge E0; first word valid after edge E2 (E1 enters RUN).
//   Back-pressure: out_valid=1 && out_ready=0 -> no load; out_data, out_last, ptr
//     and remaining frozen; out_valid never drops without handshake.
//   Handshake without new load (DRAIN) -> out_valid<=0, out_last<=0.
//   DRAIN: rom_addr=0; wait for out_valid && out_ready on last word -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE.
//   busy is high in RUN, DRAIN and DONE.
//   start while busy is ignored (not queued).
//   Last word at address DEPTH-1 is legal; ptr never exceeds DEPTH-1 on rom_addr.
//   No combinational path from out_ready to out_valid/out_data;
//   rom_rd is consumed in the same cycle rom_addr is driven.
// TESTING
//   1. Basic run, ROM[i]=i:
//      reset, start base=10 count=4, out_ready=1 -> data 10,11,12,13 on consecutive
//      cycles; out_last only on 13; done pulses 1 cycle after last handshake.
//   2. Back-pressure: same transfer, out_ready low 3 cycles after first word ->
//      word 10 held stable with out_valid=1; ptr frozen; sequence resumes intact,
//      no drop or duplicate.
//   3. Boundary: base=8096 count=4 -> words 8096..8099 with last on 8099.
//      base=8097 count=4 -> err pulse, busy never set, out_valid stays 0.
//   4. count=0: start -> no out_valid; done pulse; busy high exactly 1 cycle.
//   5. Reset mid-transfer: assert reset during word 2 of count=8 ->
//      next cycle all outputs 0, state IDLE; a new start base=0 count=2 runs cleanly.
//   6. start held high across a full transfer -> ignored while busy.
//      A second transfer begins only after return to IDLE; done pulses once per transfer.

Source files
------------

// File: rtl/dmem_stream_reader.sv
// dmem_stream_reader - walks a block of data-memory ROM words and streams them out
// over a valid/ready interface with last-word tagging, range checking and completion pulses.
module dmem_stream_reader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8100,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             req;
  logic [31:0]      req_base;
  logic [CNT_W-1:0] req_count;
  logic [31:0]      ptr;
  logic [CNT_W-1:0] remaining;
  logic [32:0]      req_end;
  logic             range_bad;
  logic             load;
  logic             take;

  // A start is latched for one cycle inside IDLE and judged the next cycle, so the
  // range compare sees registered operands and RUN is entered one edge after start.
  assign req_end   = {1'b0, req_base} + 33'(req_count);
  assign range_bad = req_end > 33'(DEPTH);
  assign take      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rom_addr  = 32'd0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_count == '0) begin
            state_nxt = DONE;
          end else if (!range_bad) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        busy     = 1'b1;
        rom_addr = ptr;
        load     = !out_valid || out_ready;
        if (load && remaining == CNT_W'(1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (take) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req       <= 1'b0;
      req_base  <= 32'd0;
      req_count <= '0;
      ptr       <= 32'd0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (req) begin
          req       <= 1'b0;
          ptr       <= req_base;
          remaining <= req_count;
          if (req_count != '0 && range_bad) begin
            err <= 1'b1;
          end
        end else if (start) begin
          req       <= 1'b1;
          req_base  <= base_addr;
          req_count <= count;
        end
      end
      // A load also consumes any word being handshaken this cycle; only a bare
      // handshake (DRAIN) empties the output register.
      if (load) begin
        out_data  <= rom_rd;
        out_valid <= 1'b1;
        out_last  <= (remaining == CNT_W'(1));
        ptr       <= ptr + 32'd1;
        remaining <= remaining - CNT_W'(1);
      end else if (take) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_stream_reader.sv
// tb_dmem_stream_reader - scenario tasks plus randomized transfers checked against
// a queue-level model of the ROM block stream.
module tb_dmem_stream_reader;

  localparam int DEPTH = 8100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [13:0] count = 14'd0;
  logic        busy, done, err;
  logic [31:0] rom_addr;
  logic [31:0] rom_rd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [31:0] salt = 32'd0;

  int errors = 0;
  int checks = 0;

  dmem_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .err(err), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // ROM image: identity when salt is zero
  assign rom_rd = rom_addr ^ salt;

  logic [31:0] obs_data[$];
  bit          obs_last[$];
  int          obs_cyc[$];
  int          addr_log[64];
  int          n_done, n_err, n_busy, first_done_cyc, err_cyc, hold_bad, addr_bad;
  bit          timed_out;
  int          stall_mask;

  // Drives one request and records everything the DUT does; judges nothing itself.
  task automatic run_xfer(input logic [31:0] b, input logic [13:0] c, input int stall_pct,
                          input bit hold_start, input int done_target, input int budget);
    bit pv, pr, pl, finished;
    logic [31:0] pd;
    int extra;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    n_done = 0; n_err = 0; n_busy = 0; first_done_cyc = -1; err_cyc = -1;
    hold_bad = 0; addr_bad = 0; timed_out = 1'b0;
    pv = 0; pr = 0; pl = 0; pd = 0; finished = 0; extra = 0;
    for (int i = 0; i < 64; i++) addr_log[i] = -1;
    @(negedge clk);
    base_addr = b; count = c; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (k < 32 && stall_mask[k]) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) >= stall_pct);
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) hold_bad++;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done_cyc < 0) first_done_cyc = k;
      end
      if (err) begin
        n_err++;
        err_cyc = k;
      end
      if (busy && rom_addr >= DEPTH) addr_bad++;
      if (!busy && rom_addr != 0) addr_bad++;
      if (k < 64) addr_log[k] = int'(rom_addr);
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_last.push_back(out_last);
        obs_cyc.push_back(k);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      if (finished) begin
        extra++;
        if (extra == 3) break;
      end else if (n_done >= done_target || n_err > 0) begin
        finished = 1;
        start = 1'b0;
      end
    end
    if (!finished) timed_out = 1'b1;
    start = 1'b0;
    stall_mask = 0;
  endtask

  // Model: number of positions where the observed stream departs from `reps` copies
  // of words ROM[b..b+c-1] with last set on each copy's final word.
  function automatic int seq_bad(input logic [31:0] b, input int c, input int reps);
    int bad = 0;
    if (obs_data.size() != c * reps) bad++;
    for (int i = 0; i < obs_data.size() && i < c * reps; i++) begin
      if (obs_data[i] !== ((b + 32'(i % c)) ^ salt)) bad++;
      if (obs_last[i] !== ((i % c) == c - 1)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, out_valid, out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, err, out_valid, out_last});
    end
    checks++;
    if (out_data !== 32'd0 || rom_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%0d addr=%0d expected 0 0", out_data, rom_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int bad;
    salt = 32'd0;
    stall_mask = 0;
    run_xfer(32'd10, 14'd4, 0, 1'b0, 1, 60);
    bad = seq_bad(32'd10, 4, 1);
    checks++;
    if (bad != 0 || timed_out) begin
      errors++;
      $display("FAIL basic_seq: got %0d words, %0d bad, timeout=%0d expected 4 words 10..13", obs_data.size(), bad, timed_out);
    end
    checks++;
    if (obs_cyc.size() != 4 || obs_cyc[0] != 2 || obs_cyc[3] != 5) begin
      errors++;
      $display("FAIL basic_latency: got first=%0d last=%0d expected 2 5", obs_cyc[0], obs_cyc[obs_cyc.size()-1]);
    end
    checks++;
    if (n_done != 1 || first_done_cyc != 6) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 6", n_done, first_done_cyc);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    stall_mask = 32'b11100;
    run_xfer(32'd10, 14'd4, 0, 1'b0, 1, 60);
    bad = seq_bad(32'd10, 4, 1);
    checks++;
    if (bad != 0 || timed_out) begin
      errors++;
      $display("FAIL bp_seq: got %0d words, %0d bad expected 4 words 10..13", obs_data.size(), bad);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad);
    end
    checks++;
    if (addr_log[3] != 11 || addr_log[4] != 11) begin
      errors++;
      $display("FAIL bp_ptr: got rom_addr %0d,%0d expected 11,11", addr_log[3], addr_log[4]);
    end
    checks++;
    if (obs_cyc.size() != 4 || obs_cyc[0] != 5 || first_done_cyc != 9) begin
      errors++;
      $display("FAIL bp_timing: got first=%0d done=%0d expected 5 9", obs_cyc[0], first_done_cyc);
    end
  endtask

  task automatic test_boundary();
    int bad;
    run_xfer(32'd8096, 14'd4, 0, 1'b0, 1, 60);
    bad = seq_bad(32'd8096, 4, 1);
    checks++;
    if (bad != 0 || n_done != 1 || addr_bad != 0) begin
      errors++;
      $display("FAIL edge_ok: got %0d words bad=%0d done=%0d addr_bad=%0d expected 4 0 1 0", obs_data.size(), bad, n_done, addr_bad);
    end
    run_xfer(32'd8097, 14'd4, 0, 1'b0, 1, 60);
    checks++;
    if (n_err != 1 || err_cyc != 1) begin
      errors++;
      $display("FAIL edge_err: got %0d pulses at %0d expected 1 at 1", n_err, err_cyc);
    end
    checks++;
    if (n_busy != 0 || obs_data.size() != 0 || n_done != 0) begin
      errors++;
      $display("FAIL edge_quiet: got busy=%0d words=%0d done=%0d expected 0 0 0", n_busy, obs_data.size(), n_done);
    end
    run_xfer(32'hFFFF_FFFE, 14'd4, 0, 1'b0, 1, 60);
    checks++;
    if (n_err != 1 || n_busy != 0 || obs_data.size() != 0) begin
      errors++;
      $display("FAIL wrap_err: got err=%0d busy=%0d words=%0d expected 1 0 0", n_err, n_busy, obs_data.size());
    end
  endtask

  task automatic test_count_zero();
    run_xfer(32'd50, 14'd0, 0, 1'b0, 1, 60);
    checks++;
    if (obs_data.size() != 0 || n_done != 1 || first_done_cyc != 1) begin
      errors++;
      $display("FAIL zero_done: got words=%0d done=%0d at %0d expected 0 1 at 1", obs_data.size(), n_done, first_done_cyc);
    end
    checks++;
    if (n_busy != 1 || n_err != 0) begin
      errors++;
      $display("FAIL zero_busy: got busy=%0d err=%0d expected 1 0", n_busy, n_err);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int bad;
    seen = 0;
    @(negedge clk);
    base_addr = 32'd100; count = 14'd8; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (out_valid && out_data == 32'd101) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_word2: got no word 101 expected it within 30 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, err, out_valid, out_last} !== 5'b0 || out_data !== 32'd0 || rom_addr !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got flags=%b data=%0d addr=%0d expected all 0",
               {busy, done, err, out_valid, out_last}, out_data, rom_addr);
    end
    run_xfer(32'd0, 14'd2, 0, 1'b0, 1, 60);
    bad = seq_bad(32'd0, 2, 1);
    checks++;
    if (bad != 0 || n_done != 1) begin
      errors++;
      $display("FAIL mid_rerun: got %0d words bad=%0d done=%0d expected 2 0 1", obs_data.size(), bad, n_done);
    end
  endtask

  task automatic test_start_held();
    int bad;
    run_xfer(32'd200, 14'd5, 20, 1'b1, 2, 200);
    bad = seq_bad(32'd200, 5, 2);
    checks++;
    if (bad != 0 || timed_out) begin
      errors++;
      $display("FAIL held_seq: got %0d words bad=%0d expected 10 words (two passes of 200..204)", obs_data.size(), bad);
    end
    checks++;
    if (n_done != 2) begin
      errors++;
      $display("FAIL held_done: got %0d pulses expected 2", n_done);
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    int c, bad;
    bit bad_range;
    for (int t = 0; t < 40; t++) begin
      salt = $urandom;
      if ($urandom_range(3) == 0) b = 32'(DEPTH - int'($urandom_range(24)));
      else b = 32'($urandom_range(DEPTH - 1));
      c = $urandom_range(20);
      bad_range = (longint'(b) + longint'(c)) > longint'(DEPTH);
      run_xfer(b, 14'(c), $urandom_range(60), 1'b0, 1, 400);
      checks++;
      if (c == 0) begin
        if (obs_data.size() != 0 || n_done != 1 || n_err != 0) begin
          errors++;
          $display("FAIL rnd_zero[%0d]: got words=%0d done=%0d err=%0d expected 0 1 0", t, obs_data.size(), n_done, n_err);
        end
      end else if (bad_range) begin
        if (n_err != 1 || n_busy != 0 || obs_data.size() != 0 || n_done != 0) begin
          errors++;
          $display("FAIL rnd_err[%0d] b=%0d c=%0d: got err=%0d busy=%0d words=%0d expected 1 0 0", t, b, c, n_err, n_busy, obs_data.size());
        end
      end else begin
        bad = seq_bad(b, c, 1);
        if (bad != 0 || n_done != 1 || hold_bad != 0 || addr_bad != 0 || timed_out) begin
          errors++;
          $display("FAIL rnd_xfer[%0d] b=%0d c=%0d: got words=%0d bad=%0d done=%0d hold=%0d addr=%0d expected %0d 0 1 0 0",
                   t, b, c, obs_data.size(), bad, n_done, hold_bad, addr_bad, c);
        end
      end
    end
    salt = 32'd0;
  endtask

  initial begin
    stall_mask = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_boundary();
    test_count_zero();
    test_reset_mid();
    test_start_held();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
